mpc_sched: RTL and testbench
============================

// Module: mpc_sched
// PURPOSE
//   Sequencer for the combinational add/sub micro-op unit (18-bit instr -> 9-bit result).
//   Buffers host micro-instructions in a small FIFO and issues them one at a time to the unit.
//   Captures each result and returns it to the host on a valid/ready channel with a sequence tag.
//   Sits between the host instruction stream and the shared ALU; the ALU itself is outside this block.
// PARAMETERS
//   DEPTH  4  FIFO entries; power of two, >=2
//   TAG_W  8  width of result sequence tag / retired-op counter
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      async active-low reset
//   in_valid     in   1      host instruction valid
//   in_instr     in   18     {code[17:16], op2[15:8], op1[7:0]}
//   in_ready     out  1      FIFO can accept (= !full)
//   flush        in   1      sync clear of FIFO, in-flight op and pending result
//   alu_instr    out  18     registered instruction driven to ALU
//   alu_result   in   9      ALU combinational result for alu_instr
//   res_valid    out  1      result available
//   res_data     out  9      captured ALU result
//   res_tag      out  TAG_W  sequence number of this result
//   res_ready    in   1      host accepts result
//   busy         out  1      state != IDLE or FIFO non-empty
// BEHAVIOUR
//   Reset (async, rst_n=0): FIFO empty, state IDLE, alu_instr=0, res_valid=0,
//     res_data=0, res_tag=0, tag counter=0; in_ready=1, busy=0.
//   Push: in_valid && in_ready at an edge writes in_instr at write pointer.
//     A push while full is not accepted even if a pop occurs in the same cycle.
//     A push into an empty FIFO is visible to the FSM on the next edge (no bypass).
//   Pointers wrap modulo DEPTH; full/empty from an extra pointer MSB.
//   FSM (one state register):
//     IDLE: if FIFO non-empty -> pop head into alu_instr, go EXEC.
//     EXEC: res_data<=alu_result, res_tag<=tag counter, tag counter+=1 (wraps modulo 2^TAG_W),
//       res_valid<=1, go DONE. ALU gets exactly one full cycle of stable alu_instr.
//     DONE: hold res_valid/res_data/res_tag until res_valid && res_ready. On that edge
//       res_valid<=0; if FIFO non-empty pop into alu_instr and go EXEC, else go IDLE.
//   Latency: push at edge N -> pop/issue at N+1 -> res_valid=1 after N+2.
//   Best throughput: one result per 2 cycles with res_ready held high.
//   alu_instr holds the last issued value outside EXEC; never changes while res_valid=1.
//   Simultaneous push and pop in one cycle: both take effect, count unchanged.
//   flush (sync, highest priority): FIFO emptied, state IDLE, res_valid<=0.
//     Push in the flush cycle is dropped. Tag counter, alu_instr and res_data keep their values.
//   Reset mid-operation: everything returns to reset values immediately.
//     In-flight op and any unaccepted result are lost.
//   Arithmetic is done only in the ALU. This block does not alter results (9-bit, modulo 512).
// TESTING
//   1 Reset: rst_n low mid-stream -> res_valid=0, alu_instr=0, in_ready=1, busy=0 asynchronously.
//   2 Single add: push 18'h00503 (code 00, op2=5, op1=3), res_ready=1
//     -> alu_instr=18'h00503 after N+1; res_valid, res_data=9'd8, res_tag=0 after N+2.
//   3 Back-pressure: res_ready=0, push continuously -> first op issued, DEPTH more accepted
//     (5 total), then in_ready=0. Raise res_ready -> results drain in push order, tags 0..4,
//     one every 2 cycles.
//   4 Sub/decrement wrap: push 18'h10503 (code 01, 3-5) -> res_data=9'h1FE;
//     push 18'h30000 (code 11, 0-1) -> res_data=9'h1FF.
//   5 Flush: 3 queued, one in DONE, pulse flush -> next edge res_valid=0, FIFO empty, busy=0.
//     Next push yields the next tag in sequence (no reuse).
//   6 Tag wrap: 257 ops with TAG_W=8 -> tag 255 followed by tag 0, then 1; no stall at wrap.

Source files
------------

// File: rtl/mpc_sched.sv
// Issue sequencer for the external add/sub micro-op ALU: FIFO-buffered host instructions,
// one op in flight at a time, tagged results returned on a valid/ready channel.
module mpc_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [17:0]      in_instr,
    output logic             in_ready,
    input  logic             flush,
    output logic [17:0]      alu_instr,
    input  logic [8:0]       alu_result,
    output logic             res_valid,
    output logic [8:0]       res_data,
    output logic [TAG_W-1:0] res_tag,
    input  logic             res_ready,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [TAG_W-1:0] TAG_ONE = {{(TAG_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [17:0]      mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic [1:0]       state;
    logic [TAG_W-1:0] tag_cnt;
    logic             full, empty, push, pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign in_ready = !full;
    assign busy     = (state != IDLE) || !empty;

    assign push = in_valid && !full && !flush;
    assign pop  = !flush && !empty &&
                  ((state == IDLE) || ((state == DONE) && res_ready));

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= in_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            rptr <= wptr;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // alu_instr only moves on a pop, so it is stable through EXEC and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_instr <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            tag_cnt   <= '0;
        end else if (flush) begin
            state     <= IDLE;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_instr <= mem[rptr[AW-1:0]];
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= alu_result;
                    res_tag   <= tag_cnt;
                    tag_cnt   <= tag_cnt + TAG_ONE;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (pop) begin
                            alu_instr <= mem[rptr[AW-1:0]];
                            state     <= EXEC;
                        end else begin
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpc_sched.sv
// Scoreboard bench for mpc_sched with a behavioural model of the external ALU.
module tb_mpc_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [17:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic [17:0] alu_instr;
    logic [8:0]  alu_result;
    logic        res_valid;
    logic [8:0]  res_data;
    logic [7:0]  res_tag;
    logic        res_ready;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0] exp_q[$];
    logic [7:0] exp_tag   = '0;
    logic [7:0] prev_tag  = '0;
    bit         have_tag  = 0;
    bit         wrap_seen = 0;
    bit         gap_mode  = 0;
    bit         have_prev = 0;
    int         prev_cyc  = 0;

    mpc_sched #(.DEPTH(4), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .alu_instr(alu_instr),
        .alu_result(alu_result), .res_valid(res_valid), .res_data(res_data),
        .res_tag(res_tag), .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [8:0] alu_f(input logic [17:0] i);
        logic [8:0] a, b;
        a = {1'b0, i[7:0]};
        b = {1'b0, i[15:8]};
        case (i[17:16])
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a + 9'd1;
            default: return a - 9'd1;
        endcase
    endfunction

    assign alu_result = alu_f(alu_instr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [17:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        for (int i = 0; i < 200 && !in_ready; i++) tick();
        if (!in_ready) chk("push_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_res();
        for (int i = 0; i < 50 && !res_valid; i++) tick();
        if (!res_valid) chk("res_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && (busy || res_valid || exp_q.size() != 0); i++) tick();
        chk("drain_q", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    // Scoreboard: expectations enter on accepted pushes, leave on accepted results.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            if (flush) begin
                if (res_valid) exp_tag++;
                exp_q.delete();
            end else begin
                if (in_valid && in_ready) exp_q.push_back(alu_f(in_instr));
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_res", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("res_data", res_data, e);
                    end
                    chk("res_tag", res_tag, exp_tag);
                    if (have_tag && prev_tag == 8'd255 && res_tag == 8'd0) wrap_seen = 1;
                    prev_tag = res_tag;
                    have_tag = 1;
                    exp_tag++;
                    if (gap_mode) begin
                        if (have_prev) chk("gap", cyc - prev_cyc, 2);
                        prev_cyc  = cyc;
                        have_prev = 1;
                    end
                end
            end
        end
    end

    initial begin
        int k;
        bit acc;
        logic [17:0] vals [8];
        rst_n = 1'b1; in_valid = 0; in_instr = '0; flush = 0; res_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu_instr", alu_instr, 0);
        chk("rst_res_tag", res_tag, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single add with latency check
        res_ready = 1'b1;
        push(18'h00503);
        tick();
        chk("t2_alu_instr", alu_instr, 18'h00503);
        tick();
        chk("t2_res_valid", res_valid, 1);
        chk("t2_res_data", res_data, 9'd8);
        chk("t2_res_tag", res_tag, 0);
        tick();

        // Subtract and decrement wrap
        push(18'h10503);
        wait_res();
        chk("t4_sub", res_data, 9'h1FE);
        tick();
        push(18'h30000);
        wait_res();
        chk("t4_dec", res_data, 9'h1FF);
        tick();
        wait_idle();

        // Back-pressure: one in flight plus DEPTH buffered
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) vals[i] = {2'(i), 8'(i * 7 + 1), 8'(i * 13 + 40)};
        k = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_instr = vals[k];
            acc = in_ready;
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("t3_accepted", k, 5);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_busy", busy, 1);
        gap_mode = 1; have_prev = 0;
        res_ready = 1'b1;
        wait_idle();
        gap_mode = 0;

        // Flush with one result held and three queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(18'h00100 + 18'(i));
        wait_res();
        tick();
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = 18'h00707;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_res_valid", res_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 1);
        res_ready = 1'b1;
        push(18'h00202);
        wait_res();
        chk("t5_next_tag", res_tag, 9);
        tick();
        wait_idle();

        // Tag wrap over 257 ops at full throughput
        gap_mode = 1; have_prev = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_instr = {2'(i), 8'(i), 8'(i * 3)};
            for (int j = 0; j < 50 && !in_ready; j++) tick();
            tick();
        end
        in_valid = 1'b0;
        wait_idle();
        gap_mode = 0;
        chk("t6_wrap_seen", wrap_seen, 1);

        // Asynchronous reset mid-stream
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(18'h00a0b + 18'(i));
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t1_res_valid", res_valid, 0);
        chk("t1_alu_instr", alu_instr, 0);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_busy", busy, 0);
        exp_q.delete();
        exp_tag = '0;
        have_tag = 0;
        tick();
        rst_n = 1'b1;
        tick();
        res_ready = 1'b1;
        push(18'h20009);
        wait_res();
        chk("t1_tag_restart", res_tag, 0);
        chk("t1_inc", res_data, 9'd10);
        tick();
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
